// File: rtl/riscv_sig_collector_if.sv
// Signature stream and sink bundle for riscv_sig_collector.
// master = signature host and output sink, slave = the collector.
interface riscv_sig_collector_if #(
   parameter int CountWidth = 16
);
   logic                  sig_start_i;
   logic                  sig_valid_i;
   logic [31:0]           sig_data_i;
   logic                  sig_end_i;
   logic                  out_valid_o;
   logic [31:0]           out_data_o;
   logic                  out_ready_i;
   logic [31:0]           crc_o;
   logic [CountWidth-1:0] word_count_o;
   logic                  done_o;
   logic                  overflow_o;

   modport master (
      output sig_start_i, sig_valid_i, sig_data_i, sig_end_i, out_ready_i,
      input  out_valid_o, out_data_o, crc_o, word_count_o, done_o, overflow_o
   );

   modport slave (
      input  sig_start_i, sig_valid_i, sig_data_i, sig_end_i, out_ready_i,
      output out_valid_o, out_data_o, crc_o, word_count_o, done_o, overflow_o
   );
endinterface

// File: rtl/riscv_sig_collector.sv
// Signature collector: running CRC-32, word count and a small output FIFO.
// Define RISCV_SIG_DUMP_EN to print popped words, the final CRC and an overflow warning.
module riscv_sig_collector #(
   parameter int FifoDepth  = 8,
   parameter int CountWidth = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   riscv_sig_collector_if.slave bus
);
   localparam int          AddrW = (FifoDepth > 2) ? $clog2(FifoDepth) : 1;
   localparam logic [31:0] Poly  = 32'hEDB88320;

`ifdef RISCV_SIG_DUMP_EN
   localparam bit DumpEn = 1'b1;
`else
   localparam bit DumpEn = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t                state_reg, state_next;
   logic [31:0]           crc_reg;
   logic [CountWidth-1:0] count_reg;
   logic [AddrW:0]        wr_ptr_reg, rd_ptr_reg;
   logic                  overflow_reg;
   logic [31:0]           mem [FifoDepth];

   logic        start, collecting, word_in, empty, full, pop, push, ovf_set, done;
   logic [31:0] crc_stage [33];

   assign start   = bus.sig_start_i;
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]) &&
                    (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]);
   assign pop     = !empty && bus.out_ready_i;
   assign word_in = collecting && bus.sig_valid_i;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign push    = word_in && (!full || pop);
   assign ovf_set = word_in && full && !pop;

   // Bit-serial reflected CRC unrolled over the word, LSB first (= LSB byte first).
   assign crc_stage[0] = crc_reg;
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_crc
         assign crc_stage[gi+1] = (crc_stage[gi] >> 1) ^
                                  ((crc_stage[gi][0] ^ bus.sig_data_i[gi]) ? Poly : 32'h0);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (start) begin
         state_next = COLLECT;
      end else begin
         case (state_reg)
            COLLECT: if (bus.sig_end_i) state_next = DRAIN;
            DRAIN:   if (empty)         state_next = DONE;
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin
      done       = (state_reg == DONE);
      collecting = (state_reg == COLLECT) && !start;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_reg      <= 32'hFFFFFFFF;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else if (start) begin
         crc_reg      <= 32'hFFFFFFFF;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (word_in) begin
            crc_reg <= crc_stage[32];
            if (count_reg != {CountWidth{1'b1}}) begin
               count_reg <= count_reg + 1'b1;
            end
         end
         if (push)    wr_ptr_reg   <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg   <= rd_ptr_reg + 1'b1;
         if (ovf_set) overflow_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg[AddrW-1:0]] <= bus.sig_data_i;
      end
   end

   // Gating the head keeps out_data_o at 0 out of reset without resetting the array.
   assign bus.out_valid_o  = !empty;
   assign bus.out_data_o   = empty ? 32'h0 : mem[rd_ptr_reg[AddrW-1:0]];
   assign bus.crc_o        = ~crc_reg;
   assign bus.word_count_o = count_reg;
   assign bus.done_o       = done;
   assign bus.overflow_o   = overflow_reg;

`ifdef RISCV_SIG_DUMP_EN
   always @(posedge clk_i) begin
      if (rst_ni && DumpEn) begin
         if (pop)
            $display("SIGNATURE: 0x%08x", bus.out_data_o);
         if (!start && state_reg == DRAIN && state_next == DONE)
            $display("SIGNATURE CRC: 0x%08x words %0d", ~crc_reg, count_reg);
         if (ovf_set && !overflow_reg)
            $display("warning: signature FIFO overflow, word dropped");
      end
   end
`endif
endmodule
